// File: rtl/bus_phase_sequencer.sv
// Bus-phase sequencer: IDLE -> ARBI -> [PREAMBLE] -> ADDRESS -> DATA -> IDLE with
// per-transaction dwell lengths latched at start, abort, and completion pulses.
module bus_phase_sequencer #(
  parameter int CNT_W       = 8,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] arbi_len_i,
  input  logic [CNT_W-1:0] pre_len_i,
  input  logic [CNT_W-1:0] addr_len_i,
  input  logic [CNT_W-1:0] data_len_i,
  output logic [2:0]       state_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] phase_cnt_o,
  output logic             txn_done_o,
  output logic             abort_ack_o
);

  // state | meaning
  // IDLE     | waiting for start
  // ARBI     | arbitration dwell
  // PREAMBLE | optional preamble dwell (pre_len != 0)
  // ADDRESS  | address dwell
  // DATA     | data dwell, valid high
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARBI     = 3'd1,
    PREAMBLE = 3'd2,
    ADDRESS  = 3'd3,
    DATA     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] arbi_len_q, pre_len_q, addr_len_q, data_len_q;
  logic             valid_q, busy_q, done_q, ack_q;
  logic             done_d, ack_d, latch_en;
  logic [CNT_W-1:0] cur_len;
  logic             last_cycle;

  always_comb begin
    cur_len = arbi_len_q;
    case (state_q)
      PREAMBLE: cur_len = pre_len_q;
      ADDRESS:  cur_len = addr_len_q;
      DATA:     cur_len = data_len_q;
      default:  cur_len = arbi_len_q;
    endcase
    // Lengths 0 and 1 both give a single-cycle phase.
    last_cycle = (cur_len <= ONE) || (cnt_q == (cur_len - ONE));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    ack_d    = 1'b0;
    latch_en = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d  = ARBI;
        cnt_d    = '0;
        latch_en = 1'b1;
      end
    end else if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      ack_d   = 1'b1;
    end else if (last_cycle) begin
      cnt_d = '0;
      case (state_q)
        ARBI:     state_d = (PREAMBLE_EN && (pre_len_q != '0)) ? PREAMBLE : ADDRESS;
        PREAMBLE: state_d = ADDRESS;
        ADDRESS:  state_d = DATA;
        default: begin
          state_d = IDLE;
          done_d  = (state_q == DATA);
        end
      endcase
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      arbi_len_q <= '0;
      pre_len_q  <= '0;
      addr_len_q <= '0;
      data_len_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == DATA);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      ack_q   <= ack_d;
      if (latch_en) begin
        arbi_len_q <= arbi_len_i;
        pre_len_q  <= pre_len_i;
        addr_len_q <= addr_len_i;
        data_len_q <= data_len_i;
      end
    end
  end

  assign state_o     = state_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;
  assign phase_cnt_o = cnt_q;
  assign txn_done_o  = done_q;
  assign abort_ack_o = ack_q;

endmodule

// File: tb/tb_bus_phase_sequencer.sv
// Directed bench for bus_phase_sequencer: expected per-cycle outputs are queued
// when stimulus is driven and compared each cycle on the falling edge.
module tb_bus_phase_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic       valid;
    logic       busy;
    logic [7:0] cnt;
    logic       done;
    logic       ack;
  } obs_t;

  logic       clk_i = 1'b0;
  logic       rst_i, start_i, abort_i;
  logic [7:0] arbi_len_i, pre_len_i, addr_len_i, data_len_i;
  logic [2:0] state_o;
  logic       valid_o, busy_o, txn_done_o, abort_ack_o;
  logic [7:0] phase_cnt_o;

  obs_t  exp_q[$];
  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  string tag    = "reset";

  always #5 clk_i = ~clk_i;

  bus_phase_sequencer #(.CNT_W(8), .PREAMBLE_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .arbi_len_i(arbi_len_i), .pre_len_i(pre_len_i),
    .addr_len_i(addr_len_i), .data_len_i(data_len_i),
    .state_o(state_o), .valid_o(valid_o), .busy_o(busy_o),
    .phase_cnt_o(phase_cnt_o), .txn_done_o(txn_done_o), .abort_ack_o(abort_ack_o)
  );

  task automatic push_phase(input logic [2:0] st, input int len);
    int n;
    obs_t e;
    n = (len == 0) ? 1 : len;
    for (int i = 0; i < n; i++) begin
      e.st = st; e.valid = (st == 3'd4); e.busy = 1'b1;
      e.cnt = 8'(i); e.done = 1'b0; e.ack = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_txn(input int a, input int p, input int x, input int d);
    push_phase(3'd1, a);
    if (p != 0) push_phase(3'd2, p);
    push_phase(3'd3, x);
    push_phase(3'd4, d);
  endtask

  task automatic push_idle(input logic done, input logic ack);
    obs_t e;
    e.st = 3'd0; e.valid = 1'b0; e.busy = 1'b0; e.cnt = 8'd0;
    e.done = done; e.ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    obs_t e, o;
    @(negedge clk_i);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = {state_o, valid_o, busy_o, phase_cnt_o, txn_done_o, abort_ack_o};
      checks++;
      assert (o === e) else begin
        fails++;
        $error("FAIL %s cyc=%0d observed st=%0d v=%b b=%b cnt=%0d done=%b ack=%b expected st=%0d v=%b b=%b cnt=%0d done=%b ack=%b",
               tag, cyc, o.st, o.valid, o.busy, o.cnt, o.done, o.ack,
               e.st, e.valid, e.busy, e.cnt, e.done, e.ack);
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      tick();
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $error("FAIL %s drain timeout observed pending=%0d expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_lens(input int a, input int p, input int x, input int d);
    arbi_len_i = 8'(a); pre_len_i = 8'(p); addr_len_i = 8'(x); data_len_i = 8'(d);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    set_lens(0, 0, 0, 0);
    tick();
    push_idle(1'b0, 1'b0);
    tick();
    rst_i = 1'b0;
    push_idle(1'b0, 1'b0);
    tick();

    tag = "preamble_txn";
    set_lens(3, 2, 4, 5); start_i = 1'b1;
    push_txn(3, 2, 4, 5); push_idle(1'b1, 1'b0); push_idle(1'b0, 1'b0);
    tick(); start_i = 1'b0;
    set_lens(7, 7, 7, 7);
    drain();

    tag = "no_preamble";
    set_lens(3, 0, 4, 5); start_i = 1'b1;
    push_txn(3, 0, 4, 5); push_idle(1'b1, 1'b0); push_idle(1'b0, 1'b0);
    tick(); start_i = 1'b0;
    drain();

    tag = "zero_lens";
    set_lens(0, 0, 0, 0); start_i = 1'b1;
    push_txn(0, 0, 0, 0); push_idle(1'b1, 1'b0); push_idle(1'b0, 1'b0);
    tick(); start_i = 1'b0;
    drain();

    tag = "abort_address";
    set_lens(3, 2, 4, 5); start_i = 1'b1;
    push_phase(3'd1, 3); push_phase(3'd2, 2); push_phase(3'd3, 2);
    push_idle(1'b0, 1'b1);
    tick(); start_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    abort_i = 1'b1;
    tick();
    tag = "abort_idle_start";
    start_i = 1'b1;
    push_txn(3, 2, 4, 5); push_idle(1'b1, 1'b0); push_idle(1'b0, 1'b0);
    tick(); start_i = 1'b0; abort_i = 1'b0;
    drain();

    tag = "abort_last_data";
    set_lens(0, 0, 0, 0); start_i = 1'b1;
    push_txn(0, 0, 0, 0); push_idle(1'b0, 1'b1); push_idle(1'b0, 1'b0);
    tick(); start_i = 1'b0;
    tick(); tick();
    abort_i = 1'b1;
    tick(); abort_i = 1'b0;
    drain();

    tag = "max_len";
    set_lens(255, 0, 0, 1); start_i = 1'b1;
    push_txn(255, 0, 0, 1); push_idle(1'b1, 1'b0); push_idle(1'b0, 1'b0);
    tick(); start_i = 1'b0;
    drain();

    tag = "back_to_back";
    set_lens(1, 1, 1, 1); start_i = 1'b1;
    push_txn(1, 1, 1, 1); push_idle(1'b1, 1'b0);
    push_txn(3, 1, 1, 1); push_idle(1'b1, 1'b0); push_idle(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) arbi_len_i = 8'd3;
      if (i == 7) arbi_len_i = 8'd1;
      if (i == 8) start_i = 1'b0;
    end
    drain();

    tag = "reset_in_data";
    set_lens(3, 2, 4, 5); start_i = 1'b1;
    push_txn(3, 2, 4, 5);
    tick(); start_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    exp_q.delete();
    rst_i = 1'b1;
    push_idle(1'b0, 1'b0); push_idle(1'b0, 1'b0);
    push_idle(1'b0, 1'b0); push_idle(1'b0, 1'b0);
    tick(); tick();
    rst_i = 1'b0;
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
